truth_table_sweeper: RTL and testbench

Sequential stimulus/capture stage placed directly upstream of the lab's 3- and 4-input combinational function modules (single output Y). It drives every input combination {A,B,C,D} in ascending order and waits a programmable settle time. It then samples the function's Y, builds the captured truth table and compares it against an expected table. It reports pass/fail, mismatch count and first failing row, so each board exercise is self-checking.

---
 rtl/truth_table_sweeper.sv | 166 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Stimulus/capture stage for small combinational functions. It drives every
//   input combination in ascending order and waits SETTLE cycles per row. It
//   then samples y_in, builds the captured truth table and compares it with
//   `expected`, reporting the mismatch count and the first failing row.
//
// Parameters
//   N_IN    number of function inputs (3 or 4); ROWS = 2**N_IN
//   SETTLE  cycles between driving a row and sampling y_in (1..15)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle sweep request (accepted in IDLE/DONE only)
//   step_en      1 = single-step (advance on step), 0 = free-run
//   step         one-cycle advance pulse, honoured only while holding a row
//   y_in         Y output of the function under test
//   expected     expected table, bit r = Y for row r (bits >= ROWS ignored)
//   abcd         stimulus {A,B,C,D}; N_IN=3 drives {1'b0,A,B,C}
//   busy         sweep in progress
//   done         sweep finished, held until next start or reset
//   pass         done with zero mismatches
//   captured     sampled table, bit r = y_in for row r
//   mismatch_cnt rows where captured != expected (0..16)
//   first_fail   lowest mismatching row, valid when fail_valid=1
//   fail_valid   at least one mismatch seen this sweep
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        step_en,
    input  logic        step,
    input  logic        y_in,
    input  logic [15:0] expected,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail,
    output logic        fail_valid
);

    localparam int         ROWS      = 1 << N_IN;
    localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state_q,      state_d;
    logic [3:0]  row_q,        row_d;
    logic [3:0]  settle_q,     settle_d;
    logic [3:0]  abcd_q,       abcd_d;
    logic [15:0] captured_q,   captured_d;
    logic [4:0]  mismatch_q,   mismatch_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        fail_valid_q, fail_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            settle_q     <= '0;
            abcd_q       <= '0;
            captured_q   <= '0;
            mismatch_q   <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            settle_q     <= settle_d;
            abcd_q       <= abcd_d;
            captured_q   <= captured_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        settle_d     = settle_q;
        abcd_d       = abcd_q;
        captured_d   = captured_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    captured_d   = '0;
                    mismatch_d   = '0;
                    first_fail_d = '0;
                    fail_valid_d = 1'b0;
                    row_d        = '0;
                    abcd_d       = '0;
                    state_d      = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_d = SETTLE_LD;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                // Counter holds the remaining settle cycles including this one.
                if (settle_q <= 4'd1) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                captured_d[row_q] = y_in;
                if (y_in != expected[row_q]) begin
                    mismatch_d = mismatch_q + 5'd1;
                    if (!fail_valid_q) begin
                        first_fail_d = row_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (row_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else if (!step_en) begin
                    // abcd is updated together with row on entry to DRIVE.
                    row_d   = row_q + 4'd1;
                    abcd_d  = row_q + 4'd1;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (step || !step_en) begin
                    row_d   = row_q + 4'd1;
                    abcd_d  = row_q + 4'd1;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign abcd         = abcd_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign pass         = (state_q == S_DONE) && (mismatch_q == 5'd0);
    assign captured     = captured_q;
    assign mismatch_cnt = mismatch_q;
    assign first_fail   = first_fail_q;
    assign fail_valid   = fail_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: one instance with N_IN=3/SETTLE=2 and
// one with N_IN=4/SETTLE=1, each driven by a table-defined function.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [2];
    logic        step_en [2];
    logic        step [2];
    logic [15:0] expected [2];
    logic [15:0] ytbl [2];
    logic [3:0]  abcd [2];
    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic [15:0] captured [2];
    logic [4:0]  mismatch_cnt [2];
    logic [3:0]  first_fail [2];
    logic        fail_valid [2];
    logic        y3, y4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign y3 = ytbl[0][abcd[0]];
    assign y4 = ytbl[1][abcd[1]];

    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .step_en(step_en[0]),
        .step(step[0]), .y_in(y3), .expected(expected[0]), .abcd(abcd[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .captured(captured[0]),
        .mismatch_cnt(mismatch_cnt[0]), .first_fail(first_fail[0]),
        .fail_valid(fail_valid[0])
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .step_en(step_en[1]),
        .step(step[1]), .y_in(y4), .expected(expected[1]), .abcd(abcd[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .captured(captured[1]),
        .mismatch_cnt(mismatch_cnt[1]), .first_fail(first_fail[1]),
        .fail_valid(fail_valid[1])
    );

    function automatic int rows_of(input int sel);
        return (sel == 0) ? 8 : 16;
    endfunction

    function automatic int settle_of(input int sel);
        return (sel == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int sel);
        chk("rst_abcd", 32'(abcd[sel]), 0);
        chk("rst_busy", 32'(busy[sel]), 0);
        chk("rst_done", 32'(done[sel]), 0);
        chk("rst_pass", 32'(pass[sel]), 0);
        chk("rst_captured", 32'(captured[sel]), 0);
        chk("rst_mismatch", 32'(mismatch_cnt[sel]), 0);
        chk("rst_first_fail", 32'(first_fail[sel]), 0);
        chk("rst_fail_valid", 32'(fail_valid[sel]), 0);
    endtask

    // Reference: captured table is the function table limited to ROWS rows;
    // mismatches are counted row by row against expected.
    task automatic check_results(input int sel);
        logic [15:0] cap = '0;
        int          cnt = 0;
        int          ff = 0;
        bit          fv = 0;
        for (int r = 0; r < rows_of(sel); r++) begin
            cap[r] = ytbl[sel][r];
            if (ytbl[sel][r] != expected[sel][r]) begin
                cnt++;
                if (!fv) begin
                    ff = r;
                    fv = 1;
                end
            end
        end
        chk("res_done", 32'(done[sel]), 1);
        chk("res_busy", 32'(busy[sel]), 0);
        chk("res_abcd_last", 32'(abcd[sel]), 32'(rows_of(sel) - 1));
        chk("res_captured", 32'(captured[sel]), 32'(cap));
        chk("res_mismatch", 32'(mismatch_cnt[sel]), 32'(cnt));
        chk("res_fail_valid", 32'(fail_valid[sel]), 32'(fv));
        if (fv) chk("res_first_fail", 32'(first_fail[sel]), 32'(ff));
        chk("res_pass", 32'(pass[sel]), 32'(cnt == 0));
    endtask

    // Issues start at a negedge; returns after the accepting edge.
    task automatic start_sweep(input int sel, input bit smode);
        step_en[sel] = smode;
        start[sel]   = 1'b1;
        @(negedge clk);
        start[sel]   = 1'b0;
        chk("start_abcd0", 32'(abcd[sel]), 0);
        chk("start_busy", 32'(busy[sel]), 1);
        chk("start_done", 32'(done[sel]), 0);
    endtask

    // Waits for done (bounded). n counts edges since the accepting edge (=1).
    // In single-step mode step is toggled randomly. If inj_row >= 0, a stray
    // start pulse is issued once while abcd equals that row.
    task automatic wait_done(input int sel, input bit smode, input int inj_row, output int n);
        logic [3:0] last = 4'd0;
        bit         injected = 0;
        n = 1;
        while (!done[sel] && n < 3000) begin
            if (smode) step[sel] = 1'($urandom_range(0, 1));
            if (inj_row >= 0 && !injected && abcd[sel] == 4'(inj_row)) begin
                start[sel] = 1'b1;
                injected   = 1;
            end else begin
                start[sel] = 1'b0;
            end
            @(negedge clk);
            n++;
            if (abcd[sel] != last) begin
                chk("abcd_ascending", 32'(abcd[sel]), 32'(last + 4'd1));
                last = abcd[sel];
            end
        end
        step[sel]  = 1'b0;
        start[sel] = 1'b0;
        chk("sweep_completed", 32'(done[sel]), 1);
    endtask

    task automatic tables_from_rule(input int sel, input int rule);
        int a, b, c;
        ytbl[sel] = '0;
        for (int r = 0; r < 8; r++) begin
            a = (r >> 2) & 1; b = (r >> 1) & 1; c = r & 1;
            if (rule == 0) ytbl[sel][r] = ((b == 0) || (c == 1));
            else           ytbl[sel][r] = (b == 0);
        end
        if (a == 0) ytbl[sel][15] = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; step_en[i] = 0; step[i] = 0;
            expected[i] = '0; ytbl[i] = '0;
        end

        // Reset state
        #2;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: N_IN=3, ~B|C, expected 0xBB, free-run timing
        tables_from_rule(0, 0);
        expected[0] = 16'h00BB;
        start_sweep(0, 0);
        wait_done(0, 0, -1, n);
        chk("t1_done_time", 32'(n), 32'(1 + rows_of(0) * (settle_of(0) + 2)));
        chk("t1_captured_lit", 32'(captured[0]), 32'h00BB);
        check_results(0);

        // Test 2: ~B against 0xBB
        tables_from_rule(0, 1);
        start_sweep(0, 0);
        wait_done(0, 0, -1, n);
        chk("t2_captured_lit", 32'(captured[0]), 32'h0033);
        chk("t2_mismatch_lit", 32'(mismatch_cnt[0]), 2);
        chk("t2_first_fail_lit", 32'(first_fail[0]), 3);
        check_results(0);

        // Test 3: N_IN=4, SETTLE=1, y=0, expected all-0 then all-1
        ytbl[1] = '0;
        expected[1] = 16'h0000;
        start_sweep(1, 0);
        wait_done(1, 0, -1, n);
        chk("t3_done_time", 32'(n), 32'(1 + rows_of(1) * (settle_of(1) + 2)));
        check_results(1);
        expected[1] = 16'hFFFF;
        start_sweep(1, 0);
        wait_done(1, 0, -1, n);
        chk("t3_mismatch16", 32'(mismatch_cnt[1]), 16);
        chk("t3_first_fail0", 32'(first_fail[1]), 0);
        check_results(1);

        // Test 4: single-step mode
        ytbl[1] = 16'hA5C3;
        expected[1] = 16'hA5C3;
        start_sweep(1, 1);
        repeat (30) @(negedge clk);
        chk("t4_hold_abcd", 32'(abcd[1]), 0);
        chk("t4_hold_busy", 32'(busy[1]), 1);
        for (int k = 1; k < 16; k++) begin
            step[1] = 1'b1;
            @(negedge clk);
            step[1] = 1'b0;
            chk("t4_step_abcd", 32'(abcd[1]), 32'(k));
            repeat (5) @(negedge clk);
        end
        check_results(1);
        step[1] = 1'b1;
        @(negedge clk);
        step[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_after_done_abcd", 32'(abcd[1]), 15);
        check_results(1);

        // Test 5: asynchronous reset mid-sweep
        ytbl[1] = 16'h3C96;
        expected[1] = 16'h3C86;
        start_sweep(1, 0);
        guard = 0;
        while (abcd[1] != 4'd5 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_reach_row5", 32'(abcd[1]), 5);
        #2 rst_n = 1'b0;
        #1;
        check_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_sweep(1, 0);
        wait_done(1, 0, -1, n);
        check_results(1);

        // Test 6: start while busy is ignored; start in DONE restarts
        tables_from_rule(0, 0);
        expected[0] = 16'h00BB;
        start_sweep(0, 0);
        wait_done(0, 0, 3, n);
        chk("t6_done_time", 32'(n), 32'(1 + rows_of(0) * (settle_of(0) + 2)));
        check_results(0);
        start_sweep(0, 0);
        chk("t6_restart_captured", 32'(captured[0]), 0);
        chk("t6_restart_mismatch", 32'(mismatch_cnt[0]), 0);
        chk("t6_restart_fail_valid", 32'(fail_valid[0]), 0);
        chk("t6_restart_pass", 32'(pass[0]), 0);
        wait_done(0, 0, -1, n);
        check_results(0);

        // Randomized sweeps
        for (int it = 0; it < 10; it++) begin
            int  sel;
            bit  smode;
            sel   = int'($urandom_range(0, 1));
            smode = 1'($urandom_range(0, 1));
            ytbl[sel] = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       expected[sel] = ytbl[sel];
                1:       expected[sel] = ytbl[sel] ^ (16'h1 << $urandom_range(0, 15));
                default: expected[sel] = 16'($urandom);
            endcase
            start_sweep(sel, smode);
            wait_done(sel, smode, -1, n);
            if (!smode)
                chk("rnd_done_time", 32'(n), 32'(1 + rows_of(sel) * (settle_of(sel) + 2)));
            check_results(sel);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
